// File: rtl/branch_ctrl_if.sv
// Signal bundle between the branch controller and the pipeline / condition unit.
// The slave side is the controller; the master side is the pipeline that drives it.
interface branch_ctrl_if #(
    parameter int CNT_W = 8
) ();
    logic             InstrValidD;
    logic [1:0]       JmpFD;
    logic             FlagWriteE;
    logic             MemBusy;
    logic             JmpSel;
    logic             CondEn;
    logic [1:0]       JmpFE;
    logic             PCSrc;
    logic             FlushD;
    logic             FlushE;
    logic             StallF;
    logic             StallD;
    logic [CNT_W-1:0] BranchCnt;
    logic [CNT_W-1:0] TakenCnt;

    modport slave (
        input  InstrValidD, JmpFD, FlagWriteE, MemBusy, JmpSel,
        output CondEn, JmpFE, PCSrc, FlushD, FlushE, StallF, StallD, BranchCnt, TakenCnt
    );

    modport master (
        output InstrValidD, JmpFD, FlagWriteE, MemBusy, JmpSel,
        input  CondEn, JmpFE, PCSrc, FlushD, FlushE, StallF, StallD, BranchCnt, TakenCnt
    );
endinterface

// File: rtl/branch_ctrl.sv
// Branch resolution controller: holds a detected branch for one resolve cycle,
// redirects the PC on taken, and keeps saturating branch statistics.
//
// state    | meaning
// RUN      | normal fetch, watching the D slot for a branch
// RESOLVE  | branch sits in E, condition unit decides taken / not taken
// REDIRECT | PC redirected, D slot holds the flushed bubble
module branch_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    branch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, RESOLVE, REDIRECT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    logic [1:0]       jmpfe, jmpfe_nxt;
    logic [CNT_W-1:0] branch_cnt, taken_cnt;
    logic             branch_inc, taken_inc;
    logic             detect;
    logic             redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            jmpfe      <= 2'b00;
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else begin
            state <= state_nxt;
            jmpfe <= jmpfe_nxt;
            if (branch_inc && branch_cnt != CNT_MAX) branch_cnt <= branch_cnt + 1'b1;
            if (taken_inc && taken_cnt != CNT_MAX)   taken_cnt  <= taken_cnt + 1'b1;
        end
    end

    // A stall freezes everything, including a pending resolution.
    always_comb begin
        state_nxt  = state;
        jmpfe_nxt  = jmpfe;
        detect     = 1'b0;
        redirect   = 1'b0;
        branch_inc = 1'b0;
        taken_inc  = 1'b0;
        if (!bus.MemBusy) begin
            case (state)
                RUN: begin
                    detect = bus.InstrValidD && (bus.JmpFD != 2'b00);
                    if (detect) begin
                        state_nxt = RESOLVE;
                        jmpfe_nxt = bus.JmpFD;
                    end else begin
                        jmpfe_nxt = 2'b00;
                    end
                end
                RESOLVE: begin
                    branch_inc = 1'b1;
                    if (bus.JmpSel) begin
                        redirect  = 1'b1;
                        taken_inc = 1'b1;
                        state_nxt = REDIRECT;
                        jmpfe_nxt = 2'b00;
                    end else begin
                        detect = bus.InstrValidD && (bus.JmpFD != 2'b00);
                        if (detect) begin
                            state_nxt = RESOLVE;
                            jmpfe_nxt = bus.JmpFD;
                        end else begin
                            state_nxt = RUN;
                            jmpfe_nxt = 2'b00;
                        end
                    end
                end
                REDIRECT: begin
                    state_nxt = RUN;
                    jmpfe_nxt = 2'b00;
                end
                default: begin
                    state_nxt = RUN;
                    jmpfe_nxt = 2'b00;
                end
            endcase
        end
    end

    // Pipeline controls are forced low while reset is held, even if MemBusy is high.
    assign bus.PCSrc     = rst & redirect;
    assign bus.FlushD    = rst & redirect;
    assign bus.FlushE    = rst & redirect;
    assign bus.StallF    = rst & bus.MemBusy;
    assign bus.StallD    = rst & bus.MemBusy;
    assign bus.CondEn    = rst & bus.FlagWriteE & ~bus.MemBusy & (state != RESOLVE);
    assign bus.JmpFE     = jmpfe;
    assign bus.BranchCnt = branch_cnt;
    assign bus.TakenCnt  = taken_cnt;
endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed scenarios plus random traffic, all checked
// against a queue-based model of pending branches and saturating counts.
module tb_branch_ctrl;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    branch_ctrl_if #(.CNT_W(CNT_W)) bus ();

    branch_ctrl #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: branches waiting for resolution, bubble after a redirect, counts
    bit [1:0] pend[$];
    bit       bubble;
    int       nb, nt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic drive(input bit iv, input bit [1:0] jf, input bit fw, input bit mb, input bit js);
        bus.InstrValidD = iv;
        bus.JmpFD       = jf;
        bus.FlagWriteE  = fw;
        bus.MemBusy     = mb;
        bus.JmpSel      = js;
    endtask

    task automatic step(input bit iv, input bit [1:0] jf, input bit fw, input bit mb, input bit js);
        bit       resolving;
        bit       taken;
        bit [1:0] fe;
        @(negedge clk);
        drive(iv, jf, fw, mb, js);
        #1;
        resolving = (pend.size() != 0);
        taken     = resolving && js && !mb;
        fe        = 2'b00;
        if (resolving) fe = pend[0];
        check_val("pcsrc",  bus.PCSrc,  taken);
        check_val("flushd", bus.FlushD, taken);
        check_val("flushe", bus.FlushE, taken);
        check_val("stallf", bus.StallF, mb);
        check_val("stalld", bus.StallD, mb);
        check_val("conden", bus.CondEn, fw && !mb && !resolving);
        check_val("jmpfe",  bus.JmpFE,  fe);
        check_val("bcnt",   bus.BranchCnt, nb);
        check_val("tcnt",   bus.TakenCnt,  nt);
        if (!mb) begin
            if (resolving) begin
                nb = (nb < CMAX) ? nb + 1 : CMAX;
                void'(pend.pop_front());
                if (js) begin
                    nt = (nt < CMAX) ? nt + 1 : CMAX;
                    bubble = 1'b1;
                end else if (iv && jf != 2'b00) begin
                    pend.push_back(jf);
                end
            end else if (bubble) begin
                bubble = 1'b0;
            end else if (iv && jf != 2'b00) begin
                pend.push_back(jf);
            end
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 2'b11, 1'b1, 1'b1, 1'b1);
        #1;
        pend.delete();
        bubble = 1'b0;
        nb = 0;
        nt = 0;
        check_val("rst_pcsrc",  bus.PCSrc,  0);
        check_val("rst_flushd", bus.FlushD, 0);
        check_val("rst_flushe", bus.FlushE, 0);
        check_val("rst_stallf", bus.StallF, 0);
        check_val("rst_stalld", bus.StallD, 0);
        check_val("rst_conden", bus.CondEn, 0);
        check_val("rst_jmpfe",  bus.JmpFE,  0);
        check_val("rst_bcnt",   bus.BranchCnt, 0);
        check_val("rst_tcnt",   bus.TakenCnt,  0);
        @(negedge clk);
        check_val("rst_hold_pcsrc", bus.PCSrc, 0);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b0;
        bubble = 1'b0;
        nb     = 0;
        nt     = 0;
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        reset_pulse();

        // taken conditional branch
        step(1, 2'b11, 0, 0, 0);
        step(0, 2'b00, 0, 0, 1);
        step(1, 2'b01, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0);
        check_val("taken_tcnt", bus.TakenCnt, 1);
        check_val("taken_bcnt", bus.BranchCnt, 1);

        // not-taken branch
        step(1, 2'b01, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0);
        check_val("nt_bcnt", bus.BranchCnt, 2);
        check_val("nt_tcnt", bus.TakenCnt, 1);

        // back-to-back: 01 not taken, then 10 taken
        step(1, 2'b01, 0, 0, 0);
        step(1, 2'b10, 0, 0, 0);
        step(0, 2'b00, 0, 0, 1);
        step(0, 2'b00, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0);
        check_val("b2b_bcnt", bus.BranchCnt, 4);
        check_val("b2b_tcnt", bus.TakenCnt, 2);

        // stall for three cycles during resolve
        step(1, 2'b11, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 2'b00, 0, 1, 1);
        step(0, 2'b00, 0, 0, 1);
        step(0, 2'b00, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0);
        check_val("stall_bcnt", bus.BranchCnt, 5);
        check_val("stall_tcnt", bus.TakenCnt, 3);

        // flag-write gating
        step(0, 2'b00, 1, 0, 0);
        step(1, 2'b01, 1, 0, 0);
        step(0, 2'b00, 1, 0, 0);
        step(0, 2'b00, 1, 1, 0);
        step(0, 2'b00, 0, 0, 0);

        // saturation
        for (int i = 0; i < 260; i++) begin
            step(1, 2'b10, 0, 0, 1);
            step(0, 2'b00, 0, 0, 1);
            step(0, 2'b00, 0, 0, 0);
        end
        check_val("sat_tcnt", bus.TakenCnt, CMAX);
        check_val("sat_bcnt", bus.BranchCnt, CMAX);

        // reset while a branch is in resolve
        step(1, 2'b01, 0, 0, 0);
        reset_pulse();
        step(0, 2'b00, 0, 0, 1);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) == 0) begin
                reset_pulse();
            end else begin
                step($urandom_range(1), 2'($urandom_range(3)), $urandom_range(1),
                     ($urandom_range(3) == 0), $urandom_range(1));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
